param_adder_accum: RTL and testbench

- Parametrised successor to the 3-bit registered ripple adder: WIDTH-bit add/subtract/accumulate unit with a valid/ready stream interface.
- One-deep registered output stage and a sample-window counter that auto-clears the accumulator after WINDOW accepted operations.
- Sits between the ui_in/uio pin decode and the output pin mux of the adder tile.

---
 rtl/param_adder_accum.sv | 98 +++++++++
 tb/tb_param_adder_accum.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/param_adder_accum.sv
// param_adder_accum: WIDTH-bit add/sub/accumulate unit behind a valid/ready
// stream. There is one registered result slot. A window counter clears the
// accumulator after WINDOW accepted ADD/SUB/ACC operations.
module param_adder_accum #(
  parameter int WIDTH  = 4,
  parameter int WINDOW = 1000,
  parameter int CNT_W  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] acc_val,
  output logic             win_done
);

  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             win_done;
  } res_t;

  res_t             res_q, res_d;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] op1, op2;
  logic             c0;
  logic [WIDTH:0]   full;
  logic             accept, is_clr, wrap;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_clr   = (mode == MODE_CLR);
  // The last op of a window still reports its computed sum. Only acc and count reset.
  assign wrap     = !is_clr && (cnt_q == LAST);

  assign sum      = res_q.sum;
  assign cout     = res_q.cout;
  assign ovf      = res_q.ovf;
  assign win_done = res_q.win_done;
  assign acc_val  = acc_q;

  // Operand selection and a single shared (WIDTH+1)-bit adder for every mode.
  always_comb begin
    op1 = a;
    op2 = b;
    c0  = cin;
    case (mode)
      MODE_SUB: begin op2 = ~b;    c0 = 1'b1; end
      MODE_ACC: begin op1 = acc_q; op2 = a; c0 = 1'b0; end
      default: ;
    endcase
    full           = {1'b0, op1} + {1'b0, op2} + {{WIDTH{1'b0}}, c0};
    res_d.sum      = full[WIDTH-1:0];
    res_d.cout     = full[WIDTH];
    res_d.ovf      = (op1[WIDTH-1] == op2[WIDTH-1]) && (full[WIDTH-1] != op1[WIDTH-1]);
    res_d.win_done = wrap;
    if (is_clr) res_d = '0;
  end

  // Result slot, accumulator and window counter. All of them advance only on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      res_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      res_q     <= res_d;
      if (is_clr || wrap) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (mode == MODE_ACC) acc_q <= full[WIDTH-1:0];
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_adder_accum.sv
// Bench for param_adder_accum with WIDTH=4 and WINDOW=4. It runs directed
// steps and then a random phase. Expectations come from an integer model of
// the arithmetic, with signed overflow judged by range.
module tb_param_adder_accum;
  localparam int W   = 4;
  localparam int WIN = 4;
  localparam int CW  = 2;
  localparam int M   = 1 << W;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, cin, out_valid, out_ready;
  logic         cout, ovf, win_done;
  logic [W-1:0] a, b, sum, acc_val;
  logic [1:0]   mode;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_ov, m_sum, m_cout, m_ovf, m_wd, m_acc, m_cnt;

  always #5 clk = ~clk;

  param_adder_accum #(.WIDTH(W), .WINDOW(WIN), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf),
    .acc_val(acc_val), .win_done(win_done)
  );

  function automatic int sx(input int v);
    return (v >= M / 2) ? v - M : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("out_valid", 32'(out_valid), m_ov);
    chk("sum",       32'(sum),       m_sum);
    chk("cout",      32'(cout),      m_cout);
    chk("ovf",       32'(ovf),       m_ovf);
    chk("win_done",  32'(win_done),  m_wd);
    chk("acc_val",   32'(acc_val),   m_acc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_ov = 0; m_sum = 0; m_cout = 0; m_ovf = 0; m_wd = 0; m_acc = 0; m_cnt = 0;
    chk_outputs();
    chk("rst_in_ready", 32'(in_ready), 1);
  endtask

  // Drive one cycle, predict its effect, then check the outputs after the edge.
  task automatic step(input int iv, input int ia, input int ib, input int ic,
                      input int im, input int ordy);
    int r, sr;
    in_valid = iv[0]; a = W'(ia); b = W'(ib); cin = ic[0]; mode = im[1:0];
    out_ready = ordy[0];
    #1;
    chk("in_ready", 32'(in_ready), (m_ov == 0 || ordy != 0) ? 1 : 0);
    if (iv != 0 && (m_ov == 0 || ordy != 0)) begin
      m_ov = 1;
      case (im)
        0: begin r = ia + ib + ic; sr = sx(ia) + sx(ib) + ic; m_cout = (r >= M) ? 1 : 0; end
        1: begin r = ia - ib + M;  sr = sx(ia) - sx(ib);      m_cout = (ia >= ib) ? 1 : 0; end
        2: begin r = m_acc + ia;   sr = sx(m_acc) + sx(ia);   m_cout = (r >= M) ? 1 : 0; end
        default: begin r = 0; sr = 0; m_cout = 0; end
      endcase
      m_sum = r % M;
      m_ovf = (sr > M / 2 - 1 || sr < -(M / 2)) ? 1 : 0;
      if (im == 3) begin
        m_acc = 0; m_cnt = 0; m_wd = 0;
      end else if (m_cnt == WIN - 1) begin
        m_acc = 0; m_cnt = 0; m_wd = 1;
      end else begin
        m_cnt++; m_wd = 0;
        if (im == 2) m_acc = m_sum;
      end
    end else if (ordy != 0) begin
      m_ov = 0;
    end
    @(posedge clk); #1;
    chk_outputs();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; mode = 2'b00;
    out_ready = 1'b1;
    do_reset();

    // ADD with signed overflow and carry
    step(1, 9, 8, 1, 0, 1);
    chk("add_sum_lit", 32'(sum), 2);
    chk("add_ovf_lit", 32'(ovf), 1);
    // SUB with borrow, then SUB with overflow
    step(1, 3, 5, 1, 1, 1);
    chk("sub1_sum_lit", 32'(sum), 14);
    chk("sub1_cout_lit", 32'(cout), 0);
    step(1, 8, 1, 0, 1, 1);
    chk("sub2_ovf_lit", 32'(ovf), 1);

    // Start a fresh window, then run ACC 5 four times. The fourth one wraps.
    step(1, 0, 0, 0, 3, 1);
    step(1, 5, 9, 1, 2, 1);
    step(1, 5, 0, 0, 2, 1);
    chk("acc2_sum_lit", 32'(sum), 10);
    step(1, 5, 0, 0, 2, 1);
    step(1, 5, 0, 0, 2, 1);
    chk("acc4_sum_lit", 32'(sum), 4);
    chk("acc4_wd_lit", 32'(win_done), 1);
    chk("acc4_acc_lit", 32'(acc_val), 0);
    step(1, 2, 0, 0, 2, 1);
    chk("acc5_sum_lit", 32'(sum), 2);

    // Backpressure: the result is held while in_valid stays up
    step(1, 1, 2, 0, 0, 1);
    step(1, 6, 7, 1, 0, 0);
    step(1, 6, 7, 1, 0, 0);
    step(1, 6, 7, 1, 0, 0);
    chk("bp_sum_held_lit", 32'(sum), 3);
    step(1, 6, 7, 1, 0, 1);
    chk("bp_sum_new_lit", 32'(sum), 14);
    step(0, 0, 0, 0, 0, 1);

    // CLR after two ACCs, then a full window
    step(1, 0, 0, 0, 3, 1);
    step(1, 3, 0, 0, 2, 1);
    step(1, 4, 0, 0, 2, 1);
    chk("acc7_lit", 32'(acc_val), 7);
    step(1, 0, 0, 0, 3, 1);
    chk("clr_acc_lit", 32'(acc_val), 0);
    for (int i = 0; i < 4; i++) step(1, i + 1, 0, 0, 2, 1);
    chk("win_last_lit", 32'(win_done), 1);

    // Reset while a result is held under backpressure
    step(1, 2, 3, 0, 2, 0);
    step(1, 2, 3, 0, 2, 0);
    do_reset();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, M - 1)),
                int'($urandom_range(0, M - 1)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
